// File: rtl/rv_shift_opstage_if.sv
// Shift-op enum plus the handshake/bypass bundle between decode, the operand stage and EX.
// Shared by rv_shift_opstage and its environment; XLEN is fixed at 32.
package rv_shift_opstage_pkg;
  typedef enum logic [1:0] {
    ALU_SLL = 2'd0,
    ALU_SRL = 2'd1,
    ALU_SRA = 2'd2
  } shift_op_e;
endpackage

interface rv_shift_opstage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  import rv_shift_opstage_pkg::*;

  logic            flush_i;
  logic            id_valid_i;
  logic            id_ready_o;
  shift_op_e       id_op_i;
  logic [RA_W-1:0] id_rs1_addr_i;
  logic [RA_W-1:0] id_rs2_addr_i;
  logic [XLEN-1:0] id_rs1_data_i;
  logic [XLEN-1:0] id_rs2_data_i;
  logic            id_use_imm_i;
  logic [4:0]      id_imm_i;
  logic [RA_W-1:0] id_rd_i;
  logic            mem_wen_i;
  logic [RA_W-1:0] mem_rd_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic            wb_wen_i;
  logic [RA_W-1:0] wb_rd_i;
  logic [XLEN-1:0] wb_wdata_i;
  logic            ex_valid_o;
  logic            ex_ready_i;
  shift_op_e       ex_op_o;
  logic [XLEN-1:0] ex_op_a_o;
  logic [XLEN-1:0] ex_op_a_rev_o;
  logic [4:0]      ex_amt_o;
  logic [RA_W-1:0] ex_rd_o;

  modport slave (
    input  flush_i, id_valid_i, id_op_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_use_imm_i, id_imm_i, id_rd_i,
           mem_wen_i, mem_rd_i, mem_wdata_i, wb_wen_i, wb_rd_i, wb_wdata_i,
           ex_ready_i,
    output id_ready_o, ex_valid_o, ex_op_o, ex_op_a_o, ex_op_a_rev_o,
           ex_amt_o, ex_rd_o
  );

  modport master (
    output flush_i, id_valid_i, id_op_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_use_imm_i, id_imm_i, id_rd_i,
           mem_wen_i, mem_rd_i, mem_wdata_i, wb_wen_i, wb_rd_i, wb_wdata_i,
           ex_ready_i,
    input  id_ready_o, ex_valid_o, ex_op_o, ex_op_a_o, ex_op_a_rev_o,
           ex_amt_o, ex_rd_o
  );
endinterface

// File: rtl/rv_shift_opstage.sv
// ID/EX operand stage for the shifter: MEM/WB bypass, amount select, bit-reversed op_a.
// Optional macro RV_SHIFT_OPSTAGE_SKID_EN adds a one-entry skid buffer with registered id_ready_o.
module rv_shift_opstage
  import rv_shift_opstage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  rv_shift_opstage_if.slave bus
);

  typedef struct packed {
    shift_op_e       op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] rev;
    logic [4:0]      amt;
    logic [RA_W-1:0] rd;
  } payload_t;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] rf_data,
    input logic            mem_wen,
    input logic [RA_W-1:0] mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_wen,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (addr == '0)                       return '0;
    else if (mem_wen && (mem_rd == addr)) return mem_data;
    else if (wb_wen && (wb_rd == addr))   return wb_data;
    else                                  return rf_data;
  endfunction

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  logic [XLEN-1:0] w_rs1_fwd;
  logic [4:0]      w_rs2_lo;
  payload_t        w_new;
  logic            w_main_free;
  logic            w_acc;
  payload_t        r_main_p0;
  logic            r_vld_p0;

  assign w_rs1_fwd = fwd_sel(bus.id_rs1_addr_i, bus.id_rs1_data_i,
                             bus.mem_wen_i, bus.mem_rd_i, bus.mem_wdata_i,
                             bus.wb_wen_i, bus.wb_rd_i, bus.wb_wdata_i);

  // Only the low five bits of rs2 ever reach the shifter, so only they are bypassed.
  always_comb begin
    w_rs2_lo = bus.id_rs2_data_i[4:0];
    if (bus.id_rs2_addr_i == '0)
      w_rs2_lo = 5'd0;
    else if (bus.mem_wen_i && (bus.mem_rd_i == bus.id_rs2_addr_i))
      w_rs2_lo = bus.mem_wdata_i[4:0];
    else if (bus.wb_wen_i && (bus.wb_rd_i == bus.id_rs2_addr_i))
      w_rs2_lo = bus.wb_wdata_i[4:0];
  end

  always_comb begin
    w_new     = '0;
    w_new.op  = bus.id_op_i;
    w_new.a   = w_rs1_fwd;
    w_new.rev = bit_rev(w_rs1_fwd);
    w_new.amt = bus.id_use_imm_i ? bus.id_imm_i : w_rs2_lo;
    w_new.rd  = bus.id_rd_i;
  end

  assign w_main_free = !r_vld_p0 || bus.ex_ready_i;
  assign w_acc       = bus.id_valid_i && bus.id_ready_o;

`ifdef RV_SHIFT_OPSTAGE_SKID_EN
  payload_t r_skid_p1;
  logic     r_skid_vld_p1;

  assign bus.id_ready_o = !r_skid_vld_p1;

  // ---- stage boundary: main + skid registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0      <= 1'b0;
      r_main_p0     <= '0;
      r_skid_vld_p1 <= 1'b0;
      r_skid_p1     <= '0;
    end else if (bus.flush_i) begin
      r_vld_p0      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld_p1) begin
        r_main_p0     <= r_skid_p1;
        r_vld_p0      <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
      end else begin
        r_vld_p0 <= w_acc;
        if (w_acc) r_main_p0 <= w_new;
      end
    end else if (w_acc) begin
      r_skid_p1     <= w_new;
      r_skid_vld_p1 <= 1'b1;
    end
  end
`else
  assign bus.id_ready_o = w_main_free;

  // ---- stage boundary: main register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0  <= 1'b0;
      r_main_p0 <= '0;
    end else if (bus.flush_i) begin
      r_vld_p0 <= 1'b0;
    end else if (w_main_free) begin
      r_vld_p0 <= w_acc;
      if (w_acc) r_main_p0 <= w_new;
    end
  end
`endif

  assign bus.ex_valid_o    = r_vld_p0;
  assign bus.ex_op_o       = r_main_p0.op;
  assign bus.ex_op_a_o     = r_main_p0.a;
  assign bus.ex_op_a_rev_o = r_main_p0.rev;
  assign bus.ex_amt_o      = r_main_p0.amt;
  assign bus.ex_rd_o       = r_main_p0.rd;

endmodule
